// File: rtl/crc_seq.sv
// crc_seq: byte-to-bit sequencer for an external bit-serial CRC engine.
// Accepts bytes on a valid/ready interface, clears the engine once per frame,
// streams DATA_W bits per byte and captures/compares the final CRC.
module crc_seq #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CRC_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              abort,
  input  logic [CRC_W-1:0]  exp_crc,
  output logic              crc_rst,
  output logic              crc_en,
  output logic              crc_data,
  input  logic [CRC_W-1:0]  crc_val,
  output logic [CRC_W-1:0]  crc_result,
  output logic              crc_ok,
  output logic              done,
  output logic [15:0]       byte_cnt,
  output logic              busy
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               frame_open_q, frame_open_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               last_q, last_d;
  logic [15:0]        byte_cnt_q, byte_cnt_d;
  logic [CRC_W-1:0]   crc_result_q, crc_result_d;
  logic               crc_ok_q, crc_ok_d;
  logic               done_q, done_d;

  logic               byte_end;
  logic               xfer;
  logic [15:0]        byte_cnt_inc;

  // Handshake and engine controls decoded from the current state
  assign byte_end     = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST);
  assign s_ready      = rst_n && !abort && ((state_q == ST_IDLE) || (byte_end && !last_q));
  assign xfer         = s_valid && s_ready;
  assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign busy         = (state_q != ST_IDLE);
  assign crc_rst      = (state_q == ST_CLR);
  assign crc_en       = (state_q == ST_SHIFT);
  assign crc_data     = (state_q == ST_SHIFT) ?
                        (MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0]) : 1'b0;
  assign crc_result   = crc_result_q;
  assign crc_ok       = crc_ok_q;
  assign done         = done_q;
  assign byte_cnt     = byte_cnt_q;

  // Next-state logic; abort overrides everything and never pulses done
  always_comb begin
    state_d      = state_q;
    frame_open_d = frame_open_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    byte_cnt_d   = byte_cnt_q;
    crc_result_d = crc_result_q;
    crc_ok_d     = crc_ok_q;
    done_d       = 1'b0;

    if (abort) begin
      state_d      = ST_IDLE;
      frame_open_d = 1'b0;
      bit_cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            shreg_d   = s_data;
            last_d    = s_last;
            bit_cnt_d = '0;
            if (frame_open_q) begin
              state_d    = ST_SHIFT;
              byte_cnt_d = byte_cnt_inc;
            end else begin
              state_d      = ST_CLR;
              byte_cnt_d   = 16'd1;
              frame_open_d = 1'b1;
            end
          end
        end
        ST_CLR: begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
        ST_SHIFT: begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          if (byte_end) begin
            bit_cnt_d = '0;
            if (xfer) begin
              shreg_d    = s_data;
              last_d     = s_last;
              byte_cnt_d = byte_cnt_inc;
            end else if (last_q) begin
              state_d = ST_CAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        ST_CAP: begin
          crc_result_d = crc_val;
          crc_ok_d     = (crc_val == exp_crc);
          done_d       = 1'b1;
          frame_open_d = 1'b0;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_open_q <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      last_q       <= 1'b0;
      byte_cnt_q   <= 16'd0;
      crc_result_q <= '0;
      crc_ok_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_open_q <= frame_open_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      last_q       <= last_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_result_q <= crc_result_d;
      crc_ok_q     <= crc_ok_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_crc_seq.sv
// tb_crc_seq: table vectors, directed corner sequences and random frames
// checked against a polynomial-division CRC-8 (x^8+x^2+x+1) reference.
module tb_crc_seq;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_last, abort;
  logic [7:0]  s_data, exp_crc, crc_val;

  logic        s_ready, crc_rst, crc_en, crc_data, crc_ok, done, busy;
  logic [7:0]  crc_result;
  logic [15:0] byte_cnt;

  logic        b_s_ready, b_crc_rst, b_crc_en, b_crc_data, b_crc_ok, b_done, b_busy;
  logic [7:0]  b_crc_result;
  logic [15:0] b_byte_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fbytes[$];
  logic [7:0] last_res;
  logic       force_en;
  logic [7:0] force_val;
  logic [7:0] eng_q;

  always #5 clk = ~clk;

  crc_seq #(.DATA_W(8), .CRC_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .abort(abort), .exp_crc(exp_crc), .crc_rst(crc_rst), .crc_en(crc_en),
    .crc_data(crc_data), .crc_val(crc_val), .crc_result(crc_result), .crc_ok(crc_ok),
    .done(done), .byte_cnt(byte_cnt), .busy(busy)
  );

  crc_seq #(.DATA_W(8), .CRC_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .s_last(s_last), .abort(abort), .exp_crc(exp_crc), .crc_rst(b_crc_rst), .crc_en(b_crc_en),
    .crc_data(b_crc_data), .crc_val(crc_val), .crc_result(b_crc_result), .crc_ok(b_crc_ok),
    .done(b_done), .byte_cnt(b_byte_cnt), .busy(b_busy)
  );

  // External bit-serial CRC-8 engine driven by the MSB-first instance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       eng_q <= 8'h00;
    else if (crc_rst) eng_q <= 8'h00;
    else if (crc_en)  eng_q <= {eng_q[6:0], 1'b0} ^ ((eng_q[7] ^ crc_data) ? 8'h07 : 8'h00);
  end
  assign crc_val = force_en ? force_val : eng_q;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cv;
    logic [7:0] ec;
    logic       ok;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc();
    logic       bits[$];
    logic [8:0] poly;
    logic [7:0] r;
    poly = 9'h107;
    foreach (fbytes[i]) for (int b = 7; b >= 0; b--) bits.push_back(fbytes[i][b]);
    for (int z = 0; z < 8; z++) bits.push_back(1'b0);
    for (int i = 0; i + 8 < bits.size(); i++)
      if (bits[i]) for (int j = 0; j < 9; j++) bits[i+j] = bits[i+j] ^ poly[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = bits[bits.size()-8+j];
    return r;
  endfunction

  // Single-byte frame with forced engine value and exact cycle timing
  task automatic run_single(input vec_t v);
    force_en = 1'b1; force_val = v.cv; exp_crc = v.ec;
    s_valid = 1'b1; s_data = v.data; s_last = 1'b1;
    @(negedge clk);
    chk("ready_idle", s_ready, 1);
    chk("busy_idle", busy, 0);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("clr_rst", crc_rst, 1);
    chk("clr_en", crc_en, 0);
    chk("clr_busy", busy, 1);
    chk("lsb_clr_rst", b_crc_rst, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("shift_en", crc_en, 1);
      chk("shift_rst", crc_rst, 0);
      chk("msb_bit", crc_data, v.data[7-k]);
      chk("lsb_bit", b_crc_data, v.data[k]);
      tick();
    end
    @(negedge clk);
    chk("cap_en", crc_en, 0);
    chk("cap_done_early", done, 0);
    chk("cap_busy", busy, 1);
    chk("cap_ready", s_ready, 0);
    chk("lsb_cap_busy", b_busy, 1);
    chk("lsb_cap_en", b_crc_en, 0);
    tick();
    @(negedge clk);
    chk("done", done, 1);
    chk("crc_result", crc_result, v.cv);
    chk("crc_ok", crc_ok, v.ok);
    chk("byte_cnt", byte_cnt, 1);
    chk("done_ready", s_ready, 1);
    chk("lsb_done", b_done, 1);
    chk("lsb_result", b_crc_result, v.cv);
    chk("lsb_ok", b_crc_ok, v.ok);
    chk("lsb_byte_cnt", b_byte_cnt, 1);
    chk("lsb_ready", b_s_ready, 1);
    tick();
    @(negedge clk);
    chk("done_cleared", done, 0);
    tick();
    last_res = v.cv;
  endtask

  // Frame from fbytes using the real engine; optional random valid gaps
  task automatic run_frame(input bit nogap, input bit good);
    int idx = 0, cyc = 0, rst_cnt = 0, en_cnt = 0, run = 0, maxrun = 0;
    bit seen = 1'b0;
    logic [7:0] want;
    want = ref_crc();
    force_en = 1'b0;
    exp_crc = good ? want : (want ^ 8'(32'd1 << $urandom_range(0, 7)));
    while (!seen && cyc < 400) begin
      if (idx < fbytes.size() && (nogap || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1; s_data = fbytes[idx]; s_last = (idx == fbytes.size() - 1);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      if (crc_rst) rst_cnt++;
      if (crc_en) begin
        en_cnt++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (done) begin
        seen = 1'b1;
        chk("frm_result", crc_result, want);
        chk("frm_ok", crc_ok, good);
        chk("frm_byte_cnt", byte_cnt, fbytes.size());
        chk("frm_en_cycles", en_cnt, 8 * fbytes.size());
        chk("frm_rst_pulses", rst_cnt, 1);
        if (nogap) chk("frm_en_run", maxrun, 8 * fbytes.size());
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("frm_done_seen", seen, 1);
    if (seen) begin
      @(negedge clk);
      chk("frm_done_once", done, 0);
      tick();
    end
    last_res = want;
  endtask

  initial begin
    tbl[0] = '{data: 8'hA5, cv: 8'h5A, ec: 8'h5A, ok: 1'b1};
    tbl[1] = '{data: 8'hA5, cv: 8'h5A, ec: 8'h00, ok: 1'b0};
    tbl[2] = '{data: 8'h01, cv: 8'h5A, ec: 8'h5A, ok: 1'b1};
    tbl[3] = '{data: 8'hFF, cv: 8'h00, ec: 8'h00, ok: 1'b1};
    tbl[4] = '{data: 8'h3C, cv: 8'hC3, ec: 8'hC4, ok: 1'b0};

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; abort = 1'b0;
    exp_crc = 8'h00; force_en = 1'b1; force_val = 8'h5A; last_res = 8'h00;

    @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_crc_rst", crc_rst, 0);
    chk("rst_crc_en", crc_en, 0);
    chk("rst_crc_data", crc_data, 0);
    chk("rst_done", done, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_result", crc_result, 0);
    chk("rst_ok", crc_ok, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);
    tick();

    for (int i = 0; i < 5; i++) run_single(tbl[i]);

    // Three bytes back to back
    fbytes = {8'h31, 8'h32, 8'h33};
    run_frame(1'b1, 1'b1);

    // Abort in the fourth SHIFT cycle
    begin
      bit done_seen = 1'b0;
      logic [7:0] prior;
      prior = last_res;
      force_en = 1'b0;
      s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b1;
      @(negedge clk); tick();
      s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk); tick();
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); tick();
      end
      abort = 1'b1;
      @(negedge clk);
      chk("abort_shift_en", crc_en, 1);
      chk("abort_ready", s_ready, 0);
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_en_off", crc_en, 0);
      chk("abort_busy", busy, 0);
      tick();
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) done_seen = 1'b1;
        tick();
      end
      chk("abort_no_done", done_seen, 0);
      chk("abort_keep_result", crc_result, prior);
      fbytes = {8'h11};
      run_frame(1'b1, 1'b1);
    end

    // Abort wins over a simultaneous transfer in IDLE
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    @(negedge clk);
    chk("abort_prio_ready", s_ready, 0);
    tick();
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("abort_prio_idle", busy, 0);
    tick();

    // Reset in the middle of SHIFT
    force_en = 1'b0;
    s_valid = 1'b1; s_data = 8'h96; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", crc_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_cnt", byte_cnt, 0);
    chk("mid_rst_result", crc_result, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", s_ready, 1);
    tick();
    fbytes = {8'h96};
    run_frame(1'b1, 1'b1);

    // Random frames with random gaps and CRC expectations
    for (int f = 0; f < 24; f++) begin
      int len;
      len = $urandom_range(1, 6);
      fbytes = {};
      for (int i = 0; i < len; i++) fbytes.push_back(8'($urandom));
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
